// File: rtl/keycode_ball_ctrl_if.sv
// Signal bundle between the SoC keycode/VGA side and keycode_ball_ctrl.
//   keycode    : HID keycode from the SoC, 0x00 = no key
//   vsync      : frame sync from the VGA controller (asynchronous to clk_clk)
//   ball_x/y   : ball centre position, unsigned pixels
//   frame_done : one-cycle pulse when ball_x/ball_y update
//   key_count  : running count of new key presses, wraps at 256
// master = driver of keycode/vsync (SoC/VGA side), slave = the controller.
interface keycode_ball_ctrl_if;
  logic [7:0] keycode;
  logic       vsync;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       frame_done;
  logic [7:0] key_count;

  modport master (
    output keycode,
    output vsync,
    input  ball_x,
    input  ball_y,
    input  frame_done,
    input  key_count
  );

  modport slave (
    input  keycode,
    input  vsync,
    output ball_x,
    output ball_y,
    output frame_done,
    output key_count
  );
endinterface

// File: rtl/keycode_ball_ctrl.sv
// Frame-synchronous ball motion controller.
// Once per vsync rising edge: decode the W/A/S/D keycode into a direction, let the screen-edge
// checks override it per axis, then step the ball position.
// Ports:
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset
//   bus (slave)   : keycode, vsync in; ball_x, ball_y, frame_done, key_count out
module keycode_ball_ctrl #(
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned X_CENTER = 320,
  parameter int unsigned Y_CENTER = 240,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SIZE     = 4
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  keycode_ball_ctrl_if.slave bus
);

  localparam logic [7:0] KeyW = 8'h1A;
  localparam logic [7:0] KeyS = 8'h16;
  localparam logic [7:0] KeyA = 8'h04;
  localparam logic [7:0] KeyD = 8'h07;

  localparam logic [9:0] StepPos = 10'(STEP);
  localparam logic [9:0] StepNeg = ~StepPos + 10'd1;
  localparam logic [9:0] XReset  = 10'(X_CENTER);
  localparam logic [9:0] YReset  = 10'(Y_CENTER);

  typedef enum logic [1:0] {StWait, StKey, StBound, StMove} state_e;

  state_e     state_q;
  logic       s1_q, s2_q, s3_q;
  logic       rise;
  logic [7:0] keycode_q;
  logic [7:0] key_count_q;
  logic [9:0] dx_q, dy_q;
  logic [9:0] ball_x_q, ball_y_q;
  logic       frame_done_q;

  // Edge checks are done in 32 bits so ball + SIZE cannot wrap.
  logic [31:0] x_ext, y_ext;
  logic        x_hi, x_lo, y_hi, y_lo;

  assign x_ext = 32'(ball_x_q);
  assign y_ext = 32'(ball_y_q);
  assign x_hi  = (x_ext + SIZE) >= X_MAX;
  assign x_lo  = x_ext <= (X_MIN + SIZE);
  assign y_hi  = (y_ext + SIZE) >= Y_MAX;
  assign y_lo  = y_ext <= (Y_MIN + SIZE);

  // vsync synchronizer; s3 only exists to form the rising-edge flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.vsync;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Key press counter: counts changes to a non-zero code, ignores releases.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      keycode_q   <= 8'h00;
      key_count_q <= 8'h00;
    end else begin
      keycode_q <= bus.keycode;
      if ((bus.keycode != keycode_q) && (bus.keycode != 8'h00)) begin
        key_count_q <= key_count_q + 8'd1;
      end
    end
  end

  // Frame FSM. A rise seen outside StWait is dropped, never queued.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= StWait;
      dx_q         <= 10'd0;
      dy_q         <= 10'd0;
      ball_x_q     <= XReset;
      ball_y_q     <= YReset;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StWait: begin
          if (rise) state_q <= StKey;
        end
        StKey: begin
          case (keycode_q)
            KeyW: begin
              dx_q <= 10'd0;
              dy_q <= StepNeg;
            end
            KeyS: begin
              dx_q <= 10'd0;
              dy_q <= StepPos;
            end
            KeyA: begin
              dx_q <= StepNeg;
              dy_q <= 10'd0;
            end
            KeyD: begin
              dx_q <= StepPos;
              dy_q <= 10'd0;
            end
            default: ;
          endcase
          state_q <= StBound;
        end
        StBound: begin
          // Edge hits override whatever the key decode chose on that axis.
          if (x_hi) dx_q <= StepNeg;
          else if (x_lo) dx_q <= StepPos;
          if (y_hi) dy_q <= StepNeg;
          else if (y_lo) dy_q <= StepPos;
          state_q <= StMove;
        end
        StMove: begin
          ball_x_q     <= ball_x_q + dx_q;
          ball_y_q     <= ball_y_q + dy_q;
          frame_done_q <= 1'b1;
          state_q      <= StWait;
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.key_count  = key_count_q;

endmodule

// File: tb/tb_keycode_ball_ctrl.sv
// Directed bench for keycode_ball_ctrl: reset, single step, direction change, edge and corner
// bounces, key counter wrap and dropped-frame behaviour.
module tb_keycode_ball_ctrl;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  int   checks = 0;
  int   failures = 0;
  int   pulses;

  keycode_ball_ctrl_if bus ();

  keycode_ball_ctrl dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(bus.ball_x), 32'(x));
    chk({tag, "_y"}, 32'(bus.ball_y), 32'(y));
  endtask

  task automatic set_key(input logic [7:0] k);
    @(posedge clk_clk);
    #1 bus.keycode = k;
  endtask

  // One vsync pulse; frame_done must appear at the negedge after the 5th edge past sampling.
  task automatic run_frame(input string tag);
    int lat;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b1;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_clk);
      lat++;
    end while (!bus.frame_done && lat < 12);
    chk({tag, "_latency"}, 32'(lat), 32'd6);
  endtask

  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) run_frame(tag);
  endtask

  task automatic do_reset();
    bus.vsync     = 1'b0;
    bus.keycode   = 8'h00;
    reset_reset_n = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1;
  endtask

  initial begin
    bus.keycode   = 8'h00;
    bus.vsync     = 1'b0;
    reset_reset_n = 1'b0;
    #12;
    chk_ball("rst_in", 320, 240);
    chk("rst_in_fd", 32'(bus.frame_done), 32'd0);
    chk("rst_in_kc", 32'(bus.key_count), 32'd0);
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    chk_ball("rst_out", 320, 240);
    chk("rst_out_fd", 32'(bus.frame_done), 32'd0);

    // Single step with exact latency.
    bus.keycode = 8'h07;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b1;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      chk("step_fd_early", 32'(bus.frame_done), 32'd0);
      @(posedge clk_clk);
    end
    @(negedge clk_clk);
    chk("step_fd_pulse", 32'(bus.frame_done), 32'd1);
    chk_ball("step1", 321, 240);
    chk("step_kc", 32'(bus.key_count), 32'd1);
    @(negedge clk_clk);
    chk("step_fd_one_cycle", 32'(bus.frame_done), 32'd0);
    bus.keycode = 8'h00;
    frames(3, "persist");
    chk_ball("persist", 324, 240);
    chk("persist_kc", 32'(bus.key_count), 32'd1);

    // Reset in the middle of MOVE aborts the update.
    @(posedge clk_clk);
    #1 bus.vsync = 1'b1;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b0;
    repeat (4) @(posedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1;
    chk_ball("midmove_rst", 320, 240);
    chk("midmove_rst_fd", 32'(bus.frame_done), 32'd0);
    chk("midmove_rst_kc", 32'(bus.key_count), 32'd0);
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_clk);
      chk("idle_fd", 32'(bus.frame_done), 32'd0);
    end
    chk_ball("idle", 320, 240);
    run_frame("zero_motion");
    chk_ball("zero_motion", 320, 240);

    // Direction change: W x2 then A x3.
    bus.keycode = 8'h1A;
    frames(2, "up");
    chk_ball("up", 320, 238);
    bus.keycode = 8'h04;
    frames(3, "left");
    chk_ball("left", 317, 238);
    chk("dir_kc", 32'(bus.key_count), 32'd2);

    // Right-edge oscillation while D is held.
    do_reset();
    bus.keycode = 8'h07;
    frames(315, "right");
    chk_ball("right315", 635, 240);
    run_frame("right");
    chk_ball("right316", 634, 240);
    run_frame("right");
    chk_ball("right317", 635, 240);
    run_frame("right");
    chk_ball("right318", 634, 240);

    // Bottom-right corner: bounce off the top edge to get dx=dy=+1, then glide diagonally.
    do_reset();
    bus.keycode = 8'h04;
    frames(156, "br_a");
    chk_ball("br_a", 164, 240);
    bus.keycode = 8'h1A;
    frames(236, "br_w");
    chk_ball("br_w", 164, 4);
    bus.keycode = 8'h07;
    run_frame("br_d");
    chk_ball("br_d", 165, 5);
    bus.keycode = 8'h00;
    frames(469, "br_glide");
    chk_ball("br_glide", 634, 474);
    run_frame("br_glide");
    chk_ball("br_corner", 635, 475);
    run_frame("br_flip");
    chk_ball("br_flip", 634, 474);
    run_frame("br_after");
    chk_ball("br_after", 633, 473);

    // Top-left corner: bounce off the bottom edge to get dx=dy=-1 on the x=y diagonal.
    do_reset();
    bus.keycode = 8'h07;
    frames(155, "tl_d");
    bus.keycode = 8'h16;
    frames(235, "tl_s");
    chk_ball("tl_s", 475, 475);
    bus.keycode = 8'h04;
    run_frame("tl_a");
    chk_ball("tl_a", 474, 474);
    bus.keycode = 8'h00;
    frames(470, "tl_glide");
    chk_ball("tl_corner", 4, 4);
    run_frame("tl_flip");
    chk_ball("tl_flip", 5, 5);
    run_frame("tl_after");
    chk_ball("tl_after", 6, 6);

    // Key counter.
    do_reset();
    set_key(8'h07);
    @(negedge clk_clk);
    chk("kc_latency_before", 32'(bus.key_count), 32'd0);
    set_key(8'h07);
    chk("kc_latency_after", 32'(bus.key_count), 32'd1);
    set_key(8'h00);
    set_key(8'h07);
    set_key(8'h1A);
    @(posedge clk_clk);
    #1;
    chk("kc_five", 32'(bus.key_count), 32'd3);
    for (int i = 0; i < 253; i++) set_key((i % 2 == 0) ? 8'h04 : 8'h16);
    @(posedge clk_clk);
    #1;
    chk("kc_wrap", 32'(bus.key_count), 32'd0);
    for (int i = 253; i < 256; i++) set_key((i % 2 == 0) ? 8'h04 : 8'h16);
    @(posedge clk_clk);
    #1;
    chk("kc_256", 32'(bus.key_count), 32'd3);

    // Second rise 3 cycles after the first lands in MOVE and is dropped.
    do_reset();
    bus.keycode = 8'h07;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b1;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b0;
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1 bus.vsync = 1'b1;
    @(posedge clk_clk);
    #1 bus.vsync = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_clk);
      if (bus.frame_done) pulses++;
    end
    chk("drop_pulses", 32'(pulses), 32'd1);
    chk_ball("drop", 321, 240);
    run_frame("drop_next");
    chk_ball("drop_next", 322, 240);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
